// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for elastic pipeline stages
//
// Purpose: state encoding, control-bundle bit indices and default widths
//          shared by pipe_slot and ex_mem_skid_stage.
// Ports:   none (package)
package pipe_pkg;

  // The encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMREAD  = 3;

  localparam int DEF_CTRL_W  = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DATA_CH = 2;
  localparam int DEF_ADDR_W  = 5;

  function automatic logic [1:0] state_count(input state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one payload register of an elastic pipeline stage
//
// Purpose: holds one control/data/rd_addr entry. Clear (reset or flush) wins
//          over load so a flushed cycle never captures the incoming entry.
// Ports:   clk_i, rst_i   clock, synchronous active-high reset
//          clr_i          synchronous clear to all-zero payload
//          load_i         capture ctrl_i/data_i/rd_addr_i
//          ctrl_o, data_o, rd_addr_o  held payload
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DATA_CH = DEF_DATA_CH,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      load_i,
  input  logic [CTRL_W-1:0]         ctrl_i,
  input  logic [DATA_CH*DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0]         rd_addr_i,
  output logic [CTRL_W-1:0]         ctrl_o,
  output logic [DATA_CH*DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0]         rd_addr_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      ctrl_o    <= '0;
      data_o    <= '0;
      rd_addr_o <= '0;
    end else if (load_i) begin
      ctrl_o    <= ctrl_i;
      data_o    <= data_i;
      rd_addr_o <= rd_addr_i;
    end
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// rtl/ex_mem_skid_stage.sv - elastic pipeline register with one-entry skid buffer
//
// Purpose: carries a control bundle, DATA_CH data channels and a destination
//          register address between pipeline stages with a valid/ready
//          handshake. in_ready_o is a decode of the state register only, so
//          back-pressure never forms a combinational path upstream.
// Ports:   clk_i, rst_i            clock, synchronous active-high reset
//          flush_i                 drop held and incoming entries (bubble)
//          in_valid_i/in_ready_o   upstream handshake
//          ctrl_i, data_i, rd_addr_i  incoming payload
//          out_valid_o/out_ready_i downstream handshake
//          ctrl_o, data_o, rd_addr_o  MAIN slot payload
//          occupancy_o             entries held (0..2)
module ex_mem_skid_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DATA_CH = DEF_DATA_CH,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [CTRL_W-1:0]         ctrl_i,
  input  logic [DATA_CH*DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0]         rd_addr_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [CTRL_W-1:0]         ctrl_o,
  output logic [DATA_CH*DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0]         rd_addr_o,
  output logic [1:0]                occupancy_o
);

  state_e state, state_nxt;

  logic accept, release_w;
  logic main_load, main_from_skid, skid_load, slots_clr;

  logic [CTRL_W-1:0]         skid_ctrl;
  logic [DATA_CH*DATA_W-1:0] skid_data;
  logic [ADDR_W-1:0]         skid_rd_addr;

  logic [CTRL_W-1:0]         main_ctrl_in;
  logic [DATA_CH*DATA_W-1:0] main_data_in;
  logic [ADDR_W-1:0]         main_rd_addr_in;

  assign in_ready_o  = (state != TWO);
  assign out_valid_o = (state != EMPTY);
  assign occupancy_o = state_count(state);

  assign accept    = in_valid_i & in_ready_o;
  assign release_w = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    slots_clr      = 1'b0;
    if (flush_i) begin
      // Clearing both slots zeroes the outputs so the bubble carries no
      // RegWrite/MemWrite; a same-cycle release is simply consumed.
      state_nxt = EMPTY;
      slots_clr = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (accept && release_w) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_nxt = TWO;
          end else if (release_w) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          // in_ready_o is low here, so only a release can happen.
          if (release_w) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  assign main_ctrl_in    = main_from_skid ? skid_ctrl    : ctrl_i;
  assign main_data_in    = main_from_skid ? skid_data    : data_i;
  assign main_rd_addr_in = main_from_skid ? skid_rd_addr : rd_addr_i;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .DATA_CH(DATA_CH),
    .ADDR_W (ADDR_W)
  ) u_main (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (slots_clr),
    .load_i   (main_load),
    .ctrl_i   (main_ctrl_in),
    .data_i   (main_data_in),
    .rd_addr_i(main_rd_addr_in),
    .ctrl_o   (ctrl_o),
    .data_o   (data_o),
    .rd_addr_o(rd_addr_o)
  );

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .DATA_CH(DATA_CH),
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (slots_clr),
    .load_i   (skid_load),
    .ctrl_i   (ctrl_i),
    .data_i   (data_i),
    .rd_addr_i(rd_addr_i),
    .ctrl_o   (skid_ctrl),
    .data_o   (skid_data),
    .rd_addr_o(skid_rd_addr)
  );

endmodule

// File: doc/ex_mem_skid_stage.md
# ex_mem_skid_stage

Parametrised, elastic successor to the fixed EX/MEM pipeline latch. It carries a control bundle, N data channels and a destination-register address from one CPU pipeline stage to the next. It adds a valid/ready handshake, a one-entry skid buffer so back-pressure never creates a combinational path upstream, and a synchronous flush that inserts a bubble. It sits between any two stages of the 5-stage core: EX/MEM first, then ID/EX and MEM/WB.

## Interface
Parameters:
- CTRL_W, 4, control bundle width (bit0 RegWrite, bit1 MemtoReg, bit2 MemWrite, bit3 MemRead)
- DATA_W, 32, width of each data channel
- DATA_CH, 2, number of data channels (ALU result, store data)
- ADDR_W, 5, destination register address width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all held and incoming entries this cycle
- in_valid_i  in  1  upstream offers an entry
- in_ready_o  out  1  stage can accept; registered decode of state only
- ctrl_i  in  CTRL_W  control bundle
- data_i  in  DATA_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- rd_addr_i  in  ADDR_W  destination register
- out_valid_o  out  1  main entry holds valid data
- out_ready_i  in  1  downstream consumes this cycle
- ctrl_o, data_o, rd_addr_o  out  as inputs  main entry payload
- occupancy_o  out  2  entries held (0, 1 or 2)

## Operation
- accept = in_valid_i & in_ready_o. release = out_valid_o & out_ready_i.
- There are two slots: MAIN drives the outputs, SKID is overflow.
- States: EMPTY (0 entries), ONE (MAIN full), TWO (MAIN and SKID full).
- in_ready_o = (state != TWO). It does not depend on out_ready_i in the same cycle.
- EMPTY: accept → load MAIN, go to ONE.
- ONE:
  - accept & release → reload MAIN, stay in ONE.
  - accept & !release → load SKID, go to TWO.
  - !accept & release → go to EMPTY.
  - otherwise hold.
- TWO: release → MAIN ← SKID, go to ONE. Otherwise hold. No accept is possible in TWO.
- Ordering is strictly FIFO. No entry is dropped or duplicated except by flush.
- Flush:
  - On flush_i, the next state is EMPTY.
  - The incoming entry in that cycle is discarded even if accept is high.
  - A release in the same cycle still counts as consumed downstream.
- Cleared outputs: reset and flush force ctrl_o=0 and rd_addr_o=0, so a bubble never writes the register file or memory. data_o is also forced to 0.
- rst_i has priority over flush_i. flush_i has priority over the handshake.
- Reset values: out_valid_o=0, in_ready_o=1, ctrl_o=0, data_o=0, rd_addr_o=0, occupancy_o=0.

## Timing
- Latency: 1 cycle. An entry accepted at edge n appears on the outputs after edge n with out_valid_o=1.
- Throughput: 1 entry/cycle while out_ready_i stays high.
- Back-pressure: after out_ready_i drops, exactly one more entry is absorbed, then in_ready_o=0 from the next edge.
- in_ready_o returns to 1 the cycle after the first release in TWO.
- Outputs change only on clock edges. The block has no combinational input-to-output path.
- Reset mid-operation (rst_i high for one edge) empties both slots. Outputs take reset values after that edge.

## Structure
- Shared package `pipe_pkg`:
  - state enum (EMPTY, ONE, TWO)
  - control bit index constants (CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMWRITE=2, CTRL_MEMREAD=3)
  - default width constants
- Sub-module `pipe_slot`:
  - payload register with load and clear inputs, parametrised on CTRL_W/DATA_W/DATA_CH/ADDR_W
  - instantiated twice (MAIN, SKID)
- The top level holds the state register, the handshake decode and the MAIN-source mux (input vs SKID).

## Test plan
- Reset: hold rst_i 2 cycles with in_valid_i=1 → out_valid_o=0, in_ready_o=1, ctrl_o=0, occupancy_o=0 throughout.
- Streaming:
  - Stimulus: out_ready_i=1; present ctrl=4'b0011, rd=5'd8, data0=32'h0000_0010 to 32'h0000_0014 on 5 consecutive cycles.
  - Response: identical sequence at outputs, each 1 cycle later; occupancy_o=1 steady.
- Back-pressure:
  - Stimulus: send A (data0=32'hA), B (data0=32'hB) with out_ready_i=0; then C is offered.
  - Response: in_ready_o=0, occupancy_o=2, C not accepted.
  - Stimulus: raise out_ready_i for 3 cycles.
  - Response: outputs A, B, C in order.
- Flush while full: in state TWO assert flush_i with in_valid_i=1 → next cycle out_valid_o=0, ctrl_o=0, rd_addr_o=0, occupancy_o=0; the flushed input never appears.
- Flush vs reset: assert rst_i and flush_i together in ONE → reset values; the following accepted entry emerges normally after 1 cycle.
- Parameter sweep: DATA_CH=3, DATA_W=16, CTRL_W=6 → per-channel values 16'h1111, 16'h2222, 16'h3333 land in the correct slices of data_o.
